// File: rtl/operand_loader_pkg.sv
// Shared types and constants for the operand loader and its address counter.
package operand_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        FIN   = 3'd4
    } state_e;

    localparam int unsigned NUM_PAIRS_DEF = 8;
    localparam int unsigned LAST_IDX      = 2 * NUM_PAIRS_DEF - 1;

    // Index of the final word of a batch for a given pair count.
    function automatic int unsigned last_idx(input int unsigned num_pairs);
        return 2 * num_pairs - 1;
    endfunction

endpackage

// File: rtl/operand_loader_addr_counter.sv
// Clear/increment counter with a terminal-count flag at LAST.
module loader_addr_counter #(
    parameter int unsigned W    = 5,
    parameter int unsigned LAST = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         tc_c
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign tc_c = (cnt_q == W'(LAST));

endmodule

// File: rtl/operand_loader.sv
// Streams operand words into the engine input memory as A/B pairs, then
// kicks the engine with a one-cycle start and waits for its completion.
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned NUM_PAIRS = 8,
    parameter int unsigned ADDR_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              calc_start,
    input  logic              calc_done,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_cnt
);

    localparam int unsigned CNT_W     = ADDR_W + 1;
    localparam int unsigned LAST_WORD = last_idx(NUM_PAIRS);

    state_e state_q, state_d;
    logic   s_ready_q, s_ready_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;
    logic   calc_start_q, calc_start_d;

    logic             accept_c;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             cnt_tc_c;
    logic [CNT_W-1:0] cnt;

    assign accept_c = s_valid & s_ready_q;

    loader_addr_counter #(
        .W    (CNT_W),
        .LAST (LAST_WORD)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .cnt  (cnt),
        .tc_c (cnt_tc_c)
    );

    // Next state, counter control, and Moore outputs decoded from the next state
    // so the registered outputs line up with the state register.
    always_comb begin
        state_d      = state_q;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    cnt_inc = 1'b1;
                    state_d = RECV;
                end
            end
            RECV: begin
                if (accept_c) begin
                    if (cnt_tc_c) begin
                        cnt_clr = 1'b1;
                        state_d = START;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            START:   state_d = WAIT;
            WAIT:    if (calc_done) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        s_ready_d    = (state_d == IDLE) || (state_d == RECV);
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == FIN);
        calc_start_d = (state_d == START);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            s_ready_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            calc_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_ready_q    <= s_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            calc_start_q <= calc_start_d;
        end
    end

    // Memory samples on the accepting edge, so the write port is combinational.
    assign mem_we     = accept_c;
    assign mem_addr   = cnt[ADDR_W-1:0];
    assign mem_wdata  = s_data;

    assign s_ready    = s_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign calc_start = calc_start_q;
    assign word_cnt   = cnt;

endmodule

// File: tb/tb_operand_loader.sv
// Scoreboard bench for operand_loader: an 8-pair instance and a 1-pair instance.
module tb_operand_loader;

    logic        clk = 1'b0;
    logic        rst;

    logic        s_valid, calc_done;
    logic [15:0] s_data;
    logic        s_ready, mem_we, calc_start, busy, done;
    logic [3:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [4:0]  word_cnt;

    logic        s_valid1, calc_done1;
    logic [15:0] s_data1;
    logic        s_ready1, mem_we1, calc_start1, busy1, done1;
    logic [0:0]  mem_addr1;
    logic [15:0] mem_wdata1;
    logic [1:0]  word_cnt1;

    int checks = 0;
    int errors = 0;
    int n_writes = 0, n_starts = 0, n_writes1 = 0, n_starts1 = 0;

    logic [19:0] q[$];
    logic [16:0] q1[$];
    logic [3:0]  exp_addr = 4'd0;
    logic [0:0]  exp_addr1 = 1'b0;

    always #5 clk = ~clk;

    operand_loader #(.DATA_W(16), .NUM_PAIRS(8), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .calc_start(calc_start), .calc_done(calc_done), .busy(busy), .done(done),
        .word_cnt(word_cnt)
    );

    operand_loader #(.DATA_W(16), .NUM_PAIRS(1), .ADDR_W(1)) dut1 (
        .clk(clk), .rst(rst), .s_valid(s_valid1), .s_data(s_data1), .s_ready(s_ready1),
        .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .calc_start(calc_start1), .calc_done(calc_done1), .busy(busy1), .done(done1),
        .word_cnt(word_cnt1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Write monitors: every write must match the oldest expected entry.
    always @(negedge clk) begin
        logic [19:0] e;
        if (mem_we) begin
            n_writes++;
            if (q.size() == 0) begin
                check("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e[19:16]));
                check("wr_data", 32'(mem_wdata), 32'(e[15:0]));
            end
        end
        if (calc_start) n_starts++;
    end

    always @(negedge clk) begin
        logic [16:0] e;
        if (mem_we1) begin
            n_writes1++;
            if (q1.size() == 0) begin
                check("unexpected_write1", 32'(mem_addr1), 32'hFFFF_FFFF);
            end else begin
                e = q1.pop_front();
                check("wr_addr1", 32'(mem_addr1), 32'(e[16]));
                check("wr_data1", 32'(mem_wdata1), 32'(e[15:0]));
            end
        end
        if (calc_start1) n_starts1++;
    end

    task automatic send_word(input logic [15:0] d);
        bit got = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        q.push_back({exp_addr, d});
        exp_addr = exp_addr + 4'd1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (s_ready) got = 1'b1;
        end
        if (!got) check("ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic send_word1(input logic [15:0] d);
        bit got = 1'b0;
        s_valid1 = 1'b1;
        s_data1  = d;
        q1.push_back({exp_addr1, d});
        exp_addr1 = exp_addr1 + 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (s_ready1) got = 1'b1;
        end
        if (!got) check("ready1_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic send_range(input int first, input int last);
        for (int k = first; k <= last; k++) send_word(16'(k));
    endtask

    // Called right after the last accept: checks the start pulse, hammers the
    // stream input during WAIT, then completes with a calc_done pulse.
    task automatic finish_batch(input int wait_n);
        check("start_pulse", 32'(calc_start), 32'd1);
        check("start_busy", 32'(busy), 32'd1);
        check("start_cnt", 32'(word_cnt), 32'd0);
        s_valid = 1'b1;
        s_data  = 16'hBEEF;
        for (int i = 0; i < wait_n; i++) begin
            @(posedge clk); #1;
            check("wait_ready", 32'(s_ready), 32'd0);
            check("wait_start", 32'(calc_start), 32'd0);
            check("wait_done", 32'(done), 32'd0);
        end
        calc_done = 1'b1;
        @(posedge clk); #1;
        calc_done = 1'b0;
        s_valid   = 1'b0;
        check("fin_done", 32'(done), 32'd1);
        check("fin_busy", 32'(busy), 32'd1);
        check("fin_ready", 32'(s_ready), 32'd0);
        @(posedge clk); #1;
        check("idle_done", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_ready", 32'(s_ready), 32'd1);
        exp_addr = 4'd0;
    endtask

    initial begin
        rst = 1'b1;
        s_valid = 1'b0; s_data = '0; calc_done = 1'b0;
        s_valid1 = 1'b0; s_data1 = '0; calc_done1 = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_ready", 32'(s_ready), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_start", 32'(calc_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cnt", 32'(word_cnt), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready", 32'(s_ready), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);

        // Batch 1: back-to-back stream, long WAIT with blocked upstream data.
        send_range(1, 16);
        finish_batch(20);

        // Batch 2: 3-cycle valid gap after word 5.
        send_range(1, 5);
        s_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("gap_we", 32'(mem_we), 32'd0);
            check("gap_cnt", 32'(word_cnt), 32'd5);
            check("gap_busy", 32'(busy), 32'd1);
        end
        send_range(6, 16);
        finish_batch(4);

        // Batch 3: calc_done during RECV is ignored.
        send_range(1, 4);
        s_valid   = 1'b0;
        calc_done = 1'b1;
        @(posedge clk); #1;
        calc_done = 1'b0;
        check("recv_done_ignored_cnt", 32'(word_cnt), 32'd4);
        check("recv_done_ignored_busy", 32'(busy), 32'd1);
        check("recv_done_ignored_ready", 32'(s_ready), 32'd1);
        check("recv_done_ignored_done", 32'(done), 32'd0);
        check("recv_done_ignored_start", 32'(calc_start), 32'd0);
        send_range(5, 16);
        finish_batch(3);

        // Asynchronous reset mid-batch after word 9.
        send_range(1, 9);
        s_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        check("midrst_ready", 32'(s_ready), 32'd0);
        check("midrst_cnt", 32'(word_cnt), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        q.delete();
        exp_addr = 4'd0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("midrst_idle_ready", 32'(s_ready), 32'd1);
        check("midrst_no_start", 32'(n_starts), 32'd3);

        // Batch 5: fresh batch from address 0; calc_done in the first WAIT cycle.
        send_range(1, 16);
        finish_batch(1);

        // One-pair instance.
        send_word1(16'h00AA);
        send_word1(16'h0055);
        s_valid1 = 1'b0;
        check("np1_start", 32'(calc_start1), 32'd1);
        @(posedge clk); #1;
        check("np1_start_off", 32'(calc_start1), 32'd0);
        calc_done1 = 1'b1;
        @(posedge clk); #1;
        calc_done1 = 1'b0;
        check("np1_done", 32'(done1), 32'd1);
        @(posedge clk); #1;
        check("np1_done_off", 32'(done1), 32'd0);
        check("np1_ready", 32'(s_ready1), 32'd1);

        repeat (2) @(posedge clk);
        #1;
        check("total_writes", 32'(n_writes), 32'd73);
        check("total_starts", 32'(n_starts), 32'd4);
        check("queue_empty", 32'(q.size()), 32'd0);
        check("np1_writes", 32'(n_writes1), 32'd2);
        check("np1_starts", 32'(n_starts1), 32'd1);
        check("np1_queue_empty", 32'(q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
